// File: rtl/compression_lane_arbiter.sv
// Round-robin packet dispatcher across N_LANES compression engines, with an order FIFO
// that re-serialises engine outputs onto one host stream in arrival order with tid restored.
module compression_lane_arbiter #(
  parameter int N_LANES         = 4,
  parameter int DATA_BITS       = 512,
  parameter int ID_BITS         = 6,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ORDER_DEPTH     = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [DATA_BITS-1:0]                 axis_host_recv_tdata,
  input  logic [DATA_BITS/8-1:0]               axis_host_recv_tkeep,
  input  logic                                 axis_host_recv_tlast,
  input  logic [ID_BITS-1:0]                   axis_host_recv_tid,
  input  logic                                 axis_host_recv_tvalid,
  output logic                                 axis_host_recv_tready,
  output logic [DATA_BITS-1:0]                 axis_host_send_tdata,
  output logic [DATA_BITS/8-1:0]               axis_host_send_tkeep,
  output logic                                 axis_host_send_tlast,
  output logic [ID_BITS-1:0]                   axis_host_send_tid,
  output logic                                 axis_host_send_tvalid,
  input  logic                                 axis_host_send_tready,
  output logic [N_LANES-1:0][DATA_BITS-1:0]    lane_in_tdata,
  output logic [N_LANES-1:0][DATA_BITS/8-1:0]  lane_in_tkeep,
  output logic [N_LANES-1:0]                   lane_in_tlast,
  output logic [N_LANES-1:0]                   lane_in_tvalid,
  input  logic [N_LANES-1:0]                   lane_in_tready,
  input  logic [N_LANES-1:0][DATA_BITS-1:0]    lane_out_tdata,
  input  logic [N_LANES-1:0][DATA_BITS/8-1:0]  lane_out_tkeep,
  input  logic [N_LANES-1:0]                   lane_out_tlast,
  input  logic [N_LANES-1:0]                   lane_out_tvalid,
  output logic [N_LANES-1:0]                   lane_out_tready
);

  localparam int LANE_W = $clog2(N_LANES);
  localparam int PTR_W  = $clog2(ORDER_DEPTH);
  localparam int ENT_W  = LANE_W + ID_BITS;

  localparam logic [0:0] D_IDLE   = 1'b0;
  localparam logic [0:0] D_STREAM = 1'b1;
  localparam logic [0:0] E_IDLE   = 1'b0;
  localparam logic [0:0] E_STREAM = 1'b1;

  logic [0:0]        d_state, e_state;
  logic [LANE_W-1:0] sel, rr_ptr, pick, head_lane;
  logic [ID_BITS-1:0] head_tid;
  logic              pick_ok, dispatch_go, recv_last_hs, send_last_hs;
  logic [3:0]        outstanding [N_LANES];
  logic [N_LANES-1:0] inc_vec, dec_vec;

  logic [ENT_W-1:0]  ord_mem [ORDER_DEPTH];
  logic [PTR_W-1:0]  ord_wr, ord_rd;
  logic [PTR_W:0]    ord_cnt;
  logic              ord_full, ord_push, ord_pop;

  // First lane after rr_ptr (wrapping) with room for another packet
  always_comb begin : pick_lane
    int cand;
    pick    = '0;
    pick_ok = 1'b0;
    cand    = 0;
    for (int k = 1; k <= N_LANES; k++) begin
      cand = (int'(rr_ptr) + k) % N_LANES;
      if (!pick_ok && (outstanding[cand] < 4'(MAX_OUTSTANDING))) begin
        pick    = LANE_W'(cand);
        pick_ok = 1'b1;
      end
    end
  end

  assign ord_full    = (ord_cnt == (PTR_W+1)'(ORDER_DEPTH));
  assign ord_pop     = (e_state == E_IDLE) && (ord_cnt != '0);
  // A same-cycle pop frees the slot, so a full FIFO does not block dispatch then
  assign dispatch_go = (d_state == D_IDLE) && axis_host_recv_tvalid && pick_ok &&
                       (!ord_full || ord_pop);
  assign ord_push    = dispatch_go;

  assign axis_host_recv_tready = (d_state == D_STREAM) && lane_in_tready[sel];
  assign recv_last_hs = axis_host_recv_tvalid && axis_host_recv_tready && axis_host_recv_tlast;

  always_comb begin
    for (int i = 0; i < N_LANES; i++) begin
      lane_in_tdata[i]  = axis_host_recv_tdata;
      lane_in_tkeep[i]  = axis_host_recv_tkeep;
      lane_in_tlast[i]  = axis_host_recv_tlast;
      lane_in_tvalid[i] = (d_state == D_STREAM) && (sel == LANE_W'(i)) && axis_host_recv_tvalid;
      lane_out_tready[i] = (e_state == E_STREAM) && (head_lane == LANE_W'(i)) &&
                           axis_host_send_tready;
    end
  end

  assign axis_host_send_tdata  = lane_out_tdata[head_lane];
  assign axis_host_send_tkeep  = lane_out_tkeep[head_lane];
  assign axis_host_send_tlast  = (e_state == E_STREAM) && lane_out_tlast[head_lane];
  assign axis_host_send_tvalid = (e_state == E_STREAM) && lane_out_tvalid[head_lane];
  assign axis_host_send_tid    = head_tid;
  assign send_last_hs = axis_host_send_tvalid && axis_host_send_tready && axis_host_send_tlast;

  always_comb begin
    for (int i = 0; i < N_LANES; i++) begin
      inc_vec[i] = dispatch_go && (pick == LANE_W'(i));
      dec_vec[i] = send_last_hs && (head_lane == LANE_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (ord_push) ord_mem[ord_wr] <= {pick, axis_host_recv_tid};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_state   <= D_IDLE;
      e_state   <= E_IDLE;
      sel       <= '0;
      rr_ptr    <= LANE_W'(N_LANES - 1);
      head_lane <= '0;
      head_tid  <= '0;
      ord_wr    <= '0;
      ord_rd    <= '0;
      ord_cnt   <= '0;
      for (int i = 0; i < N_LANES; i++) outstanding[i] <= '0;
    end else begin
      // Dispatcher
      if (dispatch_go) begin
        sel     <= pick;
        rr_ptr  <= pick;
        d_state <= D_STREAM;
      end else if ((d_state == D_STREAM) && recv_last_hs) begin
        d_state <= D_IDLE;
      end
      // Order FIFO bookkeeping
      if (ord_push) ord_wr <= ord_wr + 1'b1;
      if (ord_pop)  ord_rd <= ord_rd + 1'b1;
      if (ord_push && !ord_pop)      ord_cnt <= ord_cnt + 1'b1;
      else if (ord_pop && !ord_push) ord_cnt <= ord_cnt - 1'b1;
      // Egress
      if (ord_pop) begin
        {head_lane, head_tid} <= ord_mem[ord_rd];
        e_state <= E_STREAM;
      end else if (send_last_hs) begin
        e_state <= E_IDLE;
      end
      for (int i = 0; i < N_LANES; i++) begin
        if (inc_vec[i] && !dec_vec[i])      outstanding[i] <= outstanding[i] + 4'd1;
        else if (dec_vec[i] && !inc_vec[i]) outstanding[i] <= outstanding[i] - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_compression_lane_arbiter.sv
// Directed bench: engines are per-lane FIFOs with an output enable; host sink records every beat.
module tb_compression_lane_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] recv_tdata = '0;
  logic [3:0]  recv_tkeep = 4'hF;
  logic        recv_tlast = 1'b0;
  logic [5:0]  recv_tid = '0;
  logic        recv_tvalid = 1'b0;
  logic        recv_tready;
  logic [31:0] send_tdata;
  logic [3:0]  send_tkeep;
  logic        send_tlast;
  logic [5:0]  send_tid;
  logic        send_tvalid;
  logic        send_tready = 1'b0;
  logic [3:0][31:0] lane_in_tdata;
  logic [3:0][3:0]  lane_in_tkeep;
  logic [3:0]       lane_in_tlast, lane_in_tvalid;
  logic [3:0]       lane_in_tready = 4'hF;
  logic [3:0][31:0] lane_out_tdata;
  logic [3:0][3:0]  lane_out_tkeep;
  logic [3:0]       lane_out_tlast, lane_out_tvalid, lane_out_tready;

  compression_lane_arbiter #(
    .N_LANES(4), .DATA_BITS(32), .ID_BITS(6), .MAX_OUTSTANDING(2), .ORDER_DEPTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .axis_host_recv_tdata(recv_tdata), .axis_host_recv_tkeep(recv_tkeep),
    .axis_host_recv_tlast(recv_tlast), .axis_host_recv_tid(recv_tid),
    .axis_host_recv_tvalid(recv_tvalid), .axis_host_recv_tready(recv_tready),
    .axis_host_send_tdata(send_tdata), .axis_host_send_tkeep(send_tkeep),
    .axis_host_send_tlast(send_tlast), .axis_host_send_tid(send_tid),
    .axis_host_send_tvalid(send_tvalid), .axis_host_send_tready(send_tready),
    .lane_in_tdata(lane_in_tdata), .lane_in_tkeep(lane_in_tkeep),
    .lane_in_tlast(lane_in_tlast), .lane_in_tvalid(lane_in_tvalid),
    .lane_in_tready(lane_in_tready),
    .lane_out_tdata(lane_out_tdata), .lane_out_tkeep(lane_out_tkeep),
    .lane_out_tlast(lane_out_tlast), .lane_out_tvalid(lane_out_tvalid),
    .lane_out_tready(lane_out_tready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Engine model: store beats per lane, replay them in order when enabled
  logic [32:0] eng_mem [4][64];
  int          eng_wr [4];
  int          eng_rd [4];
  logic [3:0]  eng_en = 4'hF;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        eng_wr[i] <= 0;
        eng_rd[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (lane_in_tvalid[i] && lane_in_tready[i]) begin
          eng_mem[i][eng_wr[i] % 64] <= {lane_in_tlast[i], lane_in_tdata[i]};
          eng_wr[i] <= eng_wr[i] + 1;
        end
        if (lane_out_tvalid[i] && lane_out_tready[i]) eng_rd[i] <= eng_rd[i] + 1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_out_tvalid[i] = eng_en[i] && (eng_wr[i] != eng_rd[i]);
      lane_out_tdata[i]  = eng_mem[i][eng_rd[i] % 64][31:0];
      lane_out_tlast[i]  = eng_mem[i][eng_rd[i] % 64][32];
      lane_out_tkeep[i]  = 4'hF;
    end
  end

  logic rand_ready = 1'b0;
  logic host_ready = 1'b1;
  always @(posedge clk) send_tready <= rand_ready ? ($urandom_range(0, 1) == 1) : host_ready;

  // Capture of dispatch decisions and host output beats
  int          n_disp = 0;
  int          disp_lane [128];
  logic        in_first;
  int          n_out = 0;
  logic [5:0]  out_tid  [512];
  logic [31:0] out_data [512];
  logic        out_last [512];
  logic        hol_watch = 1'b0;
  int          hol_viol = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_first <= 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (lane_in_tvalid[i] && lane_in_tready[i]) begin
          if (in_first) begin
            disp_lane[n_disp] <= i;
            n_disp <= n_disp + 1;
          end
          in_first <= lane_in_tlast[i];
        end
      end
      if (send_tvalid && send_tready) begin
        out_tid[n_out]  <= send_tid;
        out_data[n_out] <= send_tdata;
        out_last[n_out] <= send_tlast;
        n_out <= n_out + 1;
      end
      if (hol_watch && (lane_out_tready[3:1] != 3'b000)) hol_viol <= hol_viol + 1;
    end
  end

  task automatic host_beat(input logic [5:0] tid, input logic [31:0] data, input logic last);
    int  n = 0;
    bit  hs = 1'b0;
    recv_tvalid = 1'b1;
    recv_tid    = tid;
    recv_tdata  = data;
    recv_tlast  = last;
    while (!hs && n < 2000) begin
      @(negedge clk);
      hs = recv_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) chk("recv_handshake_timeout", 64'(hs), 64'(1));
    recv_tvalid = 1'b0;
    recv_tlast  = 1'b0;
  endtask

  task automatic host_pkt(input logic [5:0] tid, input int beats, input logic [31:0] base);
    for (int b = 0; b < beats; b++) host_beat(tid, base + 32'(b), b == beats - 1);
  endtask

  task automatic wait_out(input int target);
    int n = 0;
    while (n_out < target && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("out_beat_count", 64'(n_out), 64'(target));
  endtask

  initial begin
    int o0, d0, cnt;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_recv_tready", 64'(recv_tready), 64'(0));
    chk("rst_send_tvalid", 64'(send_tvalid), 64'(0));
    chk("rst_send_tid", 64'(send_tid), 64'(0));
    chk("rst_send_tlast", 64'(send_tlast), 64'(0));
    chk("rst_lane_in_tvalid", 64'(lane_in_tvalid), 64'(0));
    chk("rst_lane_out_tready", 64'(lane_out_tready), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Eight back-to-back 3-beat packets spread over all lanes
    o0 = n_out; d0 = n_disp;
    for (int p = 0; p < 8; p++) host_pkt(6'(p), 3, 32'h100 + 32'(16 * p));
    wait_out(o0 + 24);
    for (int p = 0; p < 8; p++) begin
      chk("rr_lane", 64'(disp_lane[d0 + p]), 64'(p % 4));
      for (int b = 0; b < 3; b++) begin
        chk("bb_tid", 64'(out_tid[o0 + 3 * p + b]), 64'(p));
        chk("bb_data", 64'(out_data[o0 + 3 * p + b]), 64'(32'h100 + 32'(16 * p + b)));
      end
      chk("bb_last", 64'(out_last[o0 + 3 * p + 2]), 64'(1));
      chk("bb_notlast", 64'(out_last[o0 + 3 * p + 1]), 64'(0));
    end

    // Head-of-line: lane 0 output held back, other lanes must wait
    o0 = n_out; d0 = n_disp;
    eng_en = 4'b1110;
    for (int p = 0; p < 4; p++) host_pkt(6'(10 + p), 2, 32'h200 + 32'(16 * p));
    hol_watch = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    chk("hol_no_output", 64'(n_out), 64'(o0));
    chk("hol_other_ready", 64'(hol_viol), 64'(0));
    chk("hol_send_tvalid", 64'(send_tvalid), 64'(0));
    hol_watch = 1'b0;
    eng_en = 4'hF;
    wait_out(o0 + 8);
    for (int p = 0; p < 4; p++) begin
      chk("hol_lane", 64'(disp_lane[d0 + p]), 64'(p));
      chk("hol_order_tid", 64'(out_tid[o0 + 2 * p]), 64'(10 + p));
      chk("hol_data", 64'(out_data[o0 + 2 * p + 1]), 64'(32'h201 + 32'(16 * p)));
    end

    // All engines stalled: 4 lanes x 2 outstanding accepted, ninth stalls
    o0 = n_out; d0 = n_disp;
    eng_en = 4'h0;
    for (int p = 0; p < 8; p++) host_pkt(6'(20 + p), 1, 32'h300 + 32'(p));
    chk("stall_accepted", 64'(n_disp - d0), 64'(8));
    recv_tvalid = 1'b1; recv_tid = 6'd28; recv_tdata = 32'h308; recv_tlast = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (recv_tready) cnt++;
    end
    chk("stall_recv_tready", 64'(cnt), 64'(0));
    chk("stall_disp_count", 64'(n_disp - d0), 64'(8));
    eng_en = 4'b0001;
    host_beat(6'd28, 32'h308, 1'b1);
    chk("stall_ninth_lane", 64'(disp_lane[d0 + 8]), 64'(0));
    chk("stall_first_out", 64'(out_tid[o0]), 64'(20));
    eng_en = 4'hF;
    wait_out(o0 + 9);
    for (int p = 0; p < 9; p++) begin
      chk("stall_order_tid", 64'(out_tid[o0 + p]), 64'(20 + p));
      chk("stall_data", 64'(out_data[o0 + p]), 64'(32'h300 + 32'(p)));
    end

    // Single-beat packets with random host backpressure
    o0 = n_out;
    rand_ready = 1'b1;
    for (int p = 0; p < 12; p++) host_pkt(6'(30 + p), 1, 32'hA000 + 32'(p));
    wait_out(o0 + 12);
    repeat (20) @(posedge clk);
    #1;
    chk("sb_no_extra", 64'(n_out), 64'(o0 + 12));
    for (int p = 0; p < 12; p++) begin
      chk("sb_tid", 64'(out_tid[o0 + p]), 64'(30 + p));
      chk("sb_data", 64'(out_data[o0 + p]), 64'(32'hA000 + 32'(p)));
      chk("sb_last", 64'(out_last[o0 + p]), 64'(1));
    end
    rand_ready = 1'b0;

    // Reset while both sides are mid-packet
    host_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    host_pkt(6'd50, 3, 32'hC000);
    host_beat(6'd51, 32'hC100, 1'b0);
    host_beat(6'd51, 32'hC101, 1'b0);
    recv_tvalid = 1'b1; recv_tid = 6'd51; recv_tdata = 32'hC102; recv_tlast = 1'b0;
    #1;
    chk("pre_rst_send_tvalid", 64'(send_tvalid), 64'(1));
    chk("pre_rst_lane_in_busy", 64'(lane_in_tvalid != 4'h0), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_recv_tready", 64'(recv_tready), 64'(0));
    chk("mid_rst_send_tvalid", 64'(send_tvalid), 64'(0));
    chk("mid_rst_send_tid", 64'(send_tid), 64'(0));
    chk("mid_rst_send_tlast", 64'(send_tlast), 64'(0));
    chk("mid_rst_lane_in_tvalid", 64'(lane_in_tvalid), 64'(0));
    chk("mid_rst_lane_out_tready", 64'(lane_out_tready), 64'(0));
    recv_tvalid = 1'b0;
    host_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    o0 = n_out; d0 = n_disp;
    host_pkt(6'd52, 2, 32'hB000);
    wait_out(o0 + 2);
    chk("post_rst_lane", 64'(disp_lane[d0]), 64'(0));
    chk("post_rst_tid", 64'(out_tid[o0]), 64'(52));
    chk("post_rst_data", 64'(out_data[o0 + 1]), 64'(32'hB001));
    chk("post_rst_last", 64'(out_last[o0 + 1]), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
